// File: rtl/apb_req_arbiter.sv
// ---------------------------------------------------------------------------
// apb_req_arbiter
//
// Round-robin arbiter that shares one APB master requester port among
// NUM_REQ independent clients. One APB transfer is in flight at a time;
// completion is detected by watching psel/penable/pready on the bus, and a
// WAIT phase longer than TIMEOUT_CYCLES (0 = never) ends with an error.
//
// Ports
//   pclk, presetn          clock, asynchronous active-low reset
//   req_valid[i]           client i has a command (held until req_ready[i])
//   req_write[i]           1 = write, 0 = read
//   req_addr / req_wdata   flattened per-client address / write data
//   req_ready              one-hot accept pulse (ISSUE cycle)
//   req_done               one-hot completion pulse (DONE cycle)
//   req_err, req_rdata     result of the last transfer, held until next DONE
//   m_transfer             one-cycle start strobe to the APB master
//   m_read_write, m_addr,
//   m_wdata                command to the APB master, held ISSUE..WAIT
//   m_rdata                read data from the APB master
//   apb_psel/penable/pready  bus monitor inputs
// ---------------------------------------------------------------------------
module apb_req_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADD_WIDTH      = 9,
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                         pclk,
    input  logic                         presetn,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_write,
    input  logic [NUM_REQ*ADD_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*WIDTH-1:0]     req_wdata,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [NUM_REQ-1:0]           req_done,
    output logic                         req_err,
    output logic [WIDTH-1:0]             req_rdata,
    output logic                         m_transfer,
    output logic                         m_read_write,
    output logic [ADD_WIDTH-1:0]         m_addr,
    output logic [WIDTH-1:0]             m_wdata,
    input  logic [WIDTH-1:0]             m_rdata,
    input  logic                         apb_psel,
    input  logic                         apb_penable,
    input  logic                         apb_pready
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    localparam logic [IDX_W:0]   NUM_REQ_EXT = (IDX_W + 1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_REQ - 1);
    // Counter value during the last permitted WAIT cycle.
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t state, state_next;

    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     grant;
    logic                 lat_write;
    logic [ADD_WIDTH-1:0] lat_addr;
    logic [WIDTH-1:0]     lat_wdata;
    logic [CNT_W-1:0]     wait_cnt;
    logic [WIDTH-1:0]     rdata_q;
    logic                 err_q;

    // Unflatten the per-client command buses.
    logic [ADD_WIDTH-1:0] addr_arr  [NUM_REQ];
    logic [WIDTH-1:0]     wdata_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i]  = req_addr[i*ADD_WIDTH +: ADD_WIDTH];
        assign wdata_arr[i] = req_wdata[i*WIDTH +: WIDTH];
    end

    // Round-robin pick: first valid client at or above rr_ptr, wrapping.
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W:0]   cand_sum;
    logic [IDX_W-1:0] cand;

    // NOTE: every variable written in always_comb gets a default first so no
    // path through the block leaves it unassigned (which would infer a latch).
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = rr_ptr;
        cand_sum   = '0;
        cand       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_sum = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
            if (cand_sum >= NUM_REQ_EXT) begin
                cand_sum = cand_sum - NUM_REQ_EXT;
            end
            cand = cand_sum[IDX_W-1:0];
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    logic completion;
    logic timeout_hit;

    assign completion  = apb_psel & apb_penable & apb_pready;
    assign timeout_hit = TIMEOUT_EN && (wait_cnt == CNT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:  if (pick_found) state_next = ST_ISSUE;
            ST_ISSUE: state_next = ST_WAIT;
            // Completion is checked first so it wins over a same-cycle timeout.
            ST_WAIT:  if (completion || timeout_hit) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            rr_ptr    <= '0;
            grant     <= '0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            wait_cnt  <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        grant     <= pick_idx;
                        lat_write <= req_write[pick_idx];
                        lat_addr  <= addr_arr[pick_idx];
                        lat_wdata <= wdata_arr[pick_idx];
                    end
                end
                ST_WAIT: begin
                    if (completion) begin
                        rdata_q <= lat_write ? '0 : m_rdata;
                        err_q   <= 1'b0;
                    end else if (timeout_hit) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    rr_ptr   <= (grant == LAST_IDX) ? '0 : grant + IDX_W'(1);
                    wait_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    // Outputs are pure decodes of the state register and latched command, so
    // they drop to zero the moment presetn asserts.
    logic bus_active;

    assign bus_active   = (state == ST_ISSUE) || (state == ST_WAIT);
    assign m_transfer   = (state == ST_ISSUE);
    assign m_read_write = bus_active & lat_write;
    assign m_addr       = bus_active ? lat_addr  : '0;
    assign m_wdata      = bus_active ? lat_wdata : '0;
    assign req_ready    = (state == ST_ISSUE) ? (NUM_REQ'(1) << grant) : '0;
    assign req_done     = (state == ST_DONE)  ? (NUM_REQ'(1) << grant) : '0;
    assign req_rdata    = rdata_q;
    assign req_err      = err_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
`timescale 1ns/1ps
module tb_apb_req_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int ADD_WIDTH = 9;
    localparam int WIDTH     = 32;
    localparam int TO_CYC    = 8;

    logic                         pclk = 1'b0;
    logic                         presetn = 1'b0;
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_write;
    logic [NUM_REQ*ADD_WIDTH-1:0] req_addr;
    logic [NUM_REQ*WIDTH-1:0]     req_wdata;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ-1:0]           req_done;
    logic                         req_err;
    logic [WIDTH-1:0]             req_rdata;
    logic                         m_transfer;
    logic                         m_read_write;
    logic [ADD_WIDTH-1:0]         m_addr;
    logic [WIDTH-1:0]             m_wdata;
    logic [WIDTH-1:0]             m_rdata;
    logic                         apb_psel;
    logic                         apb_penable;
    logic                         apb_pready;

    apb_req_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .ADD_WIDTH      (ADD_WIDTH),
        .WIDTH          (WIDTH),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .pclk         (pclk),
        .presetn      (presetn),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_ready    (req_ready),
        .req_done     (req_done),
        .req_err      (req_err),
        .req_rdata    (req_rdata),
        .m_transfer   (m_transfer),
        .m_read_write (m_read_write),
        .m_addr       (m_addr),
        .m_wdata      (m_wdata),
        .m_rdata      (m_rdata),
        .apb_psel     (apb_psel),
        .apb_penable  (apb_penable),
        .apb_pready   (apb_pready)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        int          idx;
        logic        wr;
        logic [8:0]  addr;
        logic [31:0] wdata;
    } grant_t;

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } done_t;

    typedef struct {
        int wait_n;
        bit hang;
    } slave_t;

    grant_t exp_grant[$];
    done_t  exp_done[$];
    slave_t slave_q[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int comp_cyc    = -10;
    int issue_cyc   = 0;
    int phase       = 0;

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-requester command lists; a requester holds valid while it has work.
    logic        cmd_wr    [NUM_REQ][8];
    logic [8:0]  cmd_addr  [NUM_REQ][8];
    logic [31:0] cmd_wdata [NUM_REQ][8];
    int          head      [NUM_REQ];
    int          tail      [NUM_REQ];

    initial begin
        for (int i = 0; i < NUM_REQ; i++) begin
            head[i] = 0;
            tail[i] = 0;
            for (int j = 0; j < 8; j++) begin
                cmd_wr[i][j]    = 1'b0;
                cmd_addr[i][j]  = '0;
                cmd_wdata[i][j] = '0;
            end
        end
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        forever begin
            @(negedge pclk);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i] && head[i] != tail[i]) head[i]++;
                req_valid[i] = (head[i] != tail[i]);
                req_write[i] = cmd_wr[i][head[i][2:0]];
                req_addr[i*ADD_WIDTH +: ADD_WIDTH] = cmd_addr[i][head[i][2:0]];
                req_wdata[i*WIDTH +: WIDTH]        = cmd_wdata[i][head[i][2:0]];
            end
        end
    end

    // APB slave behind the master: setup the cycle after m_transfer, then
    // access with wait_n wait states (or forever when hang is set).
    logic [31:0] mem [512];

    initial begin
        slave_t cfg;
        int     wcnt;
        cfg = '{0, 1'b0};
        wcnt = 0;
        for (int a = 0; a < 512; a++) mem[a] = '0;
        mem[9'h005] = 32'hDEAD_BEEF;
        mem[9'h011] = 32'h1111_0011;
        mem[9'h013] = 32'h1313_0013;
        apb_psel = 1'b0; apb_penable = 1'b0; apb_pready = 1'b0;
        m_rdata  = 32'hBAD0_BAD0;
        forever begin
            @(posedge pclk); #1;
            if (!presetn || (phase == 2 && req_done != '0)) begin
                apb_psel = 1'b0; apb_penable = 1'b0; apb_pready = 1'b0;
                phase = 0;
            end else begin
                case (phase)
                    0: if (m_transfer) begin
                        if (slave_q.size() > 0) cfg = slave_q.pop_front();
                        else cfg = '{0, 1'b0};
                        phase = 1;
                    end
                    1: begin
                        apb_psel = 1'b1; apb_penable = 1'b0; apb_pready = 1'b0;
                        wcnt = cfg.wait_n;
                        phase = 2;
                    end
                    2: begin
                        apb_penable = 1'b1;
                        if (!cfg.hang && wcnt == 0) begin
                            apb_pready = 1'b1;
                            comp_cyc = cyc;
                            if (m_read_write) begin
                                mem[m_addr] = m_wdata;
                                m_rdata = 32'hBAD0_BAD0;
                            end else begin
                                m_rdata = mem[m_addr];
                            end
                            phase = 3;
                        end else begin
                            apb_pready = 1'b0;
                            if (wcnt > 0) wcnt--;
                        end
                    end
                    default: begin
                        apb_psel = 1'b0; apb_penable = 1'b0; apb_pready = 1'b0;
                        phase = 0;
                    end
                endcase
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT pulses ready or done.
    always @(negedge pclk) begin : monitor
        grant_t g;
        done_t  d;
        check("transfer_vs_ready", 64'(m_transfer), 64'(|req_ready));
        if (req_ready != '0) begin
            if (exp_grant.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL unexpected_ready: got %b expected no grant", req_ready);
            end else begin
                g = exp_grant.pop_front();
                check("ready_onehot", 64'(req_ready), 64'(NUM_REQ'(1) << g.idx));
                check("issue_addr", 64'(m_addr), 64'(g.addr));
                check("issue_write", 64'(m_read_write), 64'(g.wr));
                if (g.wr) check("issue_wdata", 64'(m_wdata), 64'(g.wdata));
                issue_cyc = cyc;
            end
        end
        if (req_done != '0) begin
            if (exp_done.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL unexpected_done: got %b expected no completion", req_done);
            end else begin
                d = exp_done.pop_front();
                check("done_onehot", 64'(req_done), 64'(NUM_REQ'(1) << d.idx));
                check("done_rdata", 64'(req_rdata), 64'(d.rdata));
                check("done_err", 64'(req_err), 64'(d.err));
                check("done_latency", 64'(cyc - issue_cyc), 64'(d.lat));
                if (!d.err) check("done_after_completion", 64'(cyc - comp_cyc), 64'd1);
            end
        end
    end

    task automatic issue(input int idx, input logic wr, input logic [8:0] addr,
                         input logic [31:0] wdata, input int wait_n, input bit hang,
                         input logic [31:0] exp_rdata, input logic exp_err, input int lat);
        grant_t g;
        done_t  d;
        slave_t s;
        cmd_wr[idx][tail[idx][2:0]]    = wr;
        cmd_addr[idx][tail[idx][2:0]]  = addr;
        cmd_wdata[idx][tail[idx][2:0]] = wdata;
        tail[idx]++;
        g = '{idx, wr, addr, wdata};
        d = '{idx, exp_rdata, exp_err, lat};
        s = '{wait_n, hang};
        exp_grant.push_back(g);
        exp_done.push_back(d);
        slave_q.push_back(s);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((exp_grant.size() != 0 || exp_done.size() != 0 || phase != 0) && n < budget) begin
            @(posedge pclk);
            n++;
        end
        if (exp_grant.size() != 0 || exp_done.size() != 0) begin
            vectors++; miscompares++;
            $display("FAIL %s: got %0d grants and %0d dones pending after %0d cycles, expected 0",
                     name, exp_grant.size(), exp_done.size(), budget);
            exp_grant.delete();
            exp_done.delete();
        end
        @(posedge pclk); #2;
    endtask

    task automatic wait_grant(input string name, input int budget);
        int n = 0;
        while (exp_grant.size() != 0 && n < budget) begin
            @(posedge pclk);
            n++;
        end
        if (exp_grant.size() != 0) begin
            vectors++; miscompares++;
            $display("FAIL %s: got %0d grants pending after %0d cycles, expected 0",
                     name, exp_grant.size(), budget);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        presetn = 1'b0;
        repeat (2) @(posedge pclk); #2;

        // Round robin from reset: all four requesting, requester 0 twice.
        issue(0, 1'b1, 9'h010, 32'hA0A0_0010, 0, 1'b0, 32'h0,         1'b0, 3);
        issue(1, 1'b0, 9'h011, 32'h0,         1, 1'b0, 32'h1111_0011, 1'b0, 4);
        issue(2, 1'b1, 9'h012, 32'hC0C0_0012, 2, 1'b0, 32'h0,         1'b0, 5);
        issue(3, 1'b0, 9'h013, 32'h0,         0, 1'b0, 32'h1313_0013, 1'b0, 3);
        issue(0, 1'b0, 9'h010, 32'h0,         3, 1'b0, 32'hA0A0_0010, 1'b0, 6);
        repeat (2) @(posedge pclk); #2;
        check("rst_ready",    64'(req_ready),  64'd0);
        check("rst_done",     64'(req_done),   64'd0);
        check("rst_transfer", 64'(m_transfer), 64'd0);
        check("rst_addr",     64'(m_addr),     64'd0);
        check("rst_rdata",    64'(req_rdata),  64'd0);
        check("rst_err",      64'(req_err),    64'd0);
        presetn = 1'b1;
        wait_drain("round_robin", 200);

        // Single read from requester 2.
        issue(2, 1'b0, 9'h005, 32'h0, 1, 1'b0, 32'hDEAD_BEEF, 1'b0, 4);
        wait_drain("single_read", 100);

        // Write then read-back from different requesters.
        issue(1, 1'b1, 9'h01A, 32'h1234_5678, 0, 1'b0, 32'h0, 1'b0, 3);
        wait_drain("write", 100);
        issue(3, 1'b0, 9'h01A, 32'h0, 2, 1'b0, 32'h1234_5678, 1'b0, 5);
        wait_drain("read_back", 100);

        // Timeout with pready never asserted, then normal service.
        issue(0, 1'b0, 9'h020, 32'h0, 0, 1'b1, 32'h0, 1'b1, 9);
        wait_drain("timeout", 100);
        repeat (2) @(posedge pclk); #2;
        check("err_hold",   64'(req_err),   64'd1);
        check("rdata_zero", 64'(req_rdata), 64'd0);
        issue(1, 1'b0, 9'h005, 32'h0, 0, 1'b0, 32'hDEAD_BEEF, 1'b0, 3);
        wait_drain("after_timeout", 100);

        // Completion on the last allowed WAIT cycle, then one cycle too late.
        issue(2, 1'b0, 9'h005, 32'h0, 6, 1'b0, 32'hDEAD_BEEF, 1'b0, 9);
        wait_drain("complete_at_limit", 100);
        repeat (3) @(posedge pclk); #2;
        check("rdata_hold", 64'(req_rdata), 64'hDEAD_BEEF);
        issue(3, 1'b0, 9'h005, 32'h0, 7, 1'b0, 32'h0, 1'b1, 9);
        wait_drain("complete_past_limit", 100);

        // Reset during WAIT with rr_ptr at 3; afterwards 1 wins over 3.
        issue(2, 1'b0, 9'h01A, 32'h0, 0, 1'b0, 32'h1234_5678, 1'b0, 3);
        wait_drain("pre_reset", 100);
        issue(3, 1'b0, 9'h005, 32'h0, 0, 1'b1, 32'h0, 1'b1, 9);
        wait_grant("abort_issue", 50);
        repeat (2) @(posedge pclk); #2;
        issue(1, 1'b0, 9'h01A, 32'h0, 0, 1'b0, 32'h1234_5678, 1'b0, 3);
        issue(3, 1'b0, 9'h005, 32'h0, 0, 1'b0, 32'hDEAD_BEEF, 1'b0, 3);
        presetn = 1'b0;
        #1;
        check("abort_transfer", 64'(m_transfer), 64'd0);
        check("abort_addr",     64'(m_addr),     64'd0);
        check("abort_rdata",    64'(req_rdata),  64'd0);
        check("abort_done",     64'(req_done),   64'd0);
        if (exp_done.size() > 0) exp_done.delete(0);
        repeat (3) @(posedge pclk); #2;
        presetn = 1'b1;
        wait_drain("post_reset", 100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
